// File: rtl/bus_read_seq.sv
// bus_read_seq: UART-driven bus read sequencer.
// A three-byte command (OPCODE, start address, count) launches a burst of
// single-beat bus reads. Each read yields one result record (ack flag,
// address, data), flagged by a one-cycle valid pulse. A read the slave never
// acknowledges is abandoned after TIMEOUT strobe cycles and reported with
// ack=0 and zero data.
module bus_read_seq #(
    parameter logic [7:0] OPCODE  = 8'h52,
    parameter int         TIMEOUT = 16      // 1..255 strobe cycles per read
) (
    input  logic       clk_i,
    input  logic       rst_i,
    // command byte stream from the UART receiver
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    // bus master side
    output logic [7:0] adr_o,
    output logic       stb_o,
    output logic       we_o,
    input  logic       ack_i,
    input  logic [7:0] dat_i,
    // result record
    output logic       valid,
    output logic       read_ack,
    output logic [7:0] read_adr,
    output logic [7:0] read_dat,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,   // waiting for OPCODE
        ADR,    // waiting for start address byte
        CNT,    // waiting for read count byte
        STB,    // strobing the bus for the current address
        EMIT    // presenting one result record
    } state_t;

    // Last strobe cycle before a read is given up on.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] adr_q;       // address of the read in progress
    logic [8:0] remaining;   // reads left, including the current one (1..256)
    logic [7:0] tmo_cnt;     // strobe cycles already spent on the current read
    logic       tmo_last;

    assign tmo_last = (tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: command parsing, read completion and burst end.
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // state_nxt unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: if (rx_valid && (rx_data == OPCODE)) state_nxt = ADR;
            ADR:  if (rx_valid) state_nxt = CNT;
            CNT:  if (rx_valid) state_nxt = STB;
            // An ack on the final strobe cycle still counts as acknowledged.
            STB:  if (ack_i || tmo_last) state_nxt = EMIT;
            EMIT: state_nxt = (remaining == 9'd1) ? IDLE : STB;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: command latching, timeout counting and result capture.
    // Bytes received in STB/EMIT and acks outside STB fall through untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_q     <= 8'h00;
            remaining <= 9'd0;
            tmo_cnt   <= 8'h00;
            read_ack  <= 1'b0;
            read_adr  <= 8'h00;
            read_dat  <= 8'h00;
        end else begin
            case (state)
                ADR: begin
                    if (rx_valid) adr_q <= rx_data;
                end
                CNT: begin
                    if (rx_valid) begin
                        // A count of zero encodes a full 256-read sweep.
                        remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        tmo_cnt   <= 8'h00;
                    end
                end
                STB: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (ack_i) begin
                        read_ack <= 1'b1;
                        read_adr <= adr_q;
                        read_dat <= dat_i;
                    end else if (tmo_last) begin
                        read_ack <= 1'b0;
                        read_adr <= adr_q;
                        read_dat <= 8'h00;
                    end
                end
                EMIT: begin
                    // Fresh timeout budget for the next strobe phase.
                    tmo_cnt   <= 8'h00;
                    remaining <= remaining - 9'd1;
                    if (remaining != 9'd1) adr_q <= adr_q + 8'd1;  // wraps FF->00
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded straight from registered state.
    assign stb_o = (state == STB);
    assign valid = (state == EMIT);
    assign busy  = (state != IDLE);
    assign adr_o = adr_q;
    assign we_o  = 1'b0;

endmodule

// File: doc/bus_read_seq.md
BUS_READ_SEQ -- requirements
Module: bus_read_seq

Interface
REQ-001 Parameter OPCODE, 8'h52, command byte that starts a read burst.
REQ-002 Parameter TIMEOUT, 16, maximum strobe cycles per read before abort (range 1..255).
REQ-003 clk_i  in  1  single system clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 rx_data  in  8  command byte from UART receiver.
REQ-006 rx_valid  in  1  rx_data valid this cycle (one-cycle pulse per byte).
REQ-007 adr_o  out  8  bus read address.
REQ-008 stb_o  out  1  bus strobe.
REQ-009 we_o  out  1  bus write enable, constant 0.
REQ-010 ack_i  in  1  bus acknowledge.
REQ-011 dat_i  in  8  bus read data, valid with ack_i.
REQ-012 valid  out  1  one-cycle pulse: result record present on read_*.
REQ-013 read_ack  out  1  1 = slave acknowledged, 0 = timed out.
REQ-014 read_adr  out  8  address of reported read.
REQ-015 read_dat  out  8  data of reported read (8'h00 on timeout).
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 Command = 3 bytes: OPCODE, start address A, count N; N=0 SHALL mean 256 reads.
REQ-018 States SHALL be IDLE, ADR, CNT, STB, EMIT; all outputs registered or decoded from registered state.
REQ-019 IDLE: rx_valid with rx_data==OPCODE -> ADR; any other byte SHALL be discarded, state unchanged.
REQ-020 ADR: rx_valid -> latch A into address register -> CNT.
REQ-021 CNT: rx_valid -> latch N into 9-bit remaining counter (0 loaded as 256) -> STB.
REQ-022 STB: stb_o=1, adr_o=address register; timeout counter cleared on entry, +1 per STB cycle.
REQ-023 STB with ack_i=1: capture dat_i, result ack=1 -> EMIT.
REQ-024 STB with ack_i=0 on the TIMEOUT-th cycle: result ack=0, data 8'h00 -> EMIT; stb_o thus high exactly TIMEOUT cycles.
REQ-025 ack_i=1 on the TIMEOUT-th cycle SHALL be treated as acknowledged.
REQ-026 ack_i while stb_o=0 SHALL be ignored.
REQ-027 EMIT: valid=1 for exactly that one cycle, stb_o=0, read_adr/read_dat/read_ack hold result.
REQ-028 EMIT exit: remaining==1 -> IDLE; else address+1 (mod 256, 8'hFF wraps to 8'h00), remaining-1 -> STB.
REQ-029 Acked-first-cycle reads SHALL sustain one result per 2 clocks; stb_o low at least one cycle between reads.
REQ-030 rx_valid bytes arriving in STB or EMIT SHALL be dropped without effect.
REQ-031 read_* SHALL hold last values between valid pulses; consumers sample only when valid=1.
REQ-032 Exactly N (or 256) valid pulses SHALL be produced per command, in ascending address order.

Reset
REQ-033 rst_i=1 at a clock edge SHALL force state IDLE, stb_o=0, we_o=0, valid=0, busy=0, adr_o=0, read_ack=0, read_adr=0, read_dat=0, counters 0.
REQ-034 Reset mid-burst SHALL abort with no further valid pulse; stb_o low from the next edge.
REQ-035 After reset the block SHALL require a full new 3-byte command.

Verification
REQ-036 Bytes 52,10,03; slave acks first strobe cycle with dat=adr^FF -> 3 valid pulses, 2 clocks apart: (1,10,EF),(1,11,EE),(1,12,ED); busy drops after third.
REQ-037 Bytes 52,40,01; no ack -> stb_o high exactly 16 cycles, then valid with (0,40,00).
REQ-038 Bytes 52,FE,03; ack always -> addresses FE,FF,00 reported.
REQ-039 Bytes 52,00,00; ack always -> exactly 256 valid pulses, addresses 00..FF.
REQ-040 Stray byte 41 in IDLE, then bytes injected during STB -> 41 ignored, mid-burst bytes dropped, burst result count unchanged.
REQ-041 rst_i pulsed while stb_o=1 in a 5-read burst -> stb_o=0 next edge, no further valid, busy=0.
